// File: rtl/trg_in_decode.sv
// Trigger-line receiver: synchronises the active-low trigger line, classifies
// low pulses by width, issues local triggers and verifies the periodic ID check pulse.
module trg_in_decode #(
  parameter int unsigned TRG_MIN_WIDTH = 16,
  parameter int unsigned TRG_MAX_WIDTH = 24,
  parameter int unsigned CHK_WIN       = 20,
  parameter int unsigned CHK_MIN_WIDTH = 40,
  parameter int unsigned CHK_MAX_WIDTH = 60,
  parameter int unsigned STUCK_LIMIT   = 250
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        trg_in_N,
  input  logic        trg_enb_in,
  input  logic        cnt_clr_in,
  output logic        trg_out,
  output logic [15:0] trg_id_out,
  output logic        chk_ok_out,
  output logic        chk_err_out,
  output logic        busy_out,
  output logic        stuck_out,
  output logic [7:0]  err_cnt_out,
  output logic [7:0]  glitch_cnt_out
);

  localparam logic [7:0] TRG_MIN    = 8'(TRG_MIN_WIDTH);
  localparam logic [7:0] TRG_MAX    = 8'(TRG_MAX_WIDTH);
  localparam logic [7:0] CHK_MIN    = 8'(CHK_MIN_WIDTH);
  localparam logic [7:0] CHK_MAX    = 8'(CHK_MAX_WIDTH);
  localparam logic [7:0] CHK_LAST   = 8'(CHK_WIN - 1);
  localparam logic [7:0] STUCK_LAST = 8'(STUCK_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRG_HI,
    S_CHK_WAIT,
    S_CHK_HI,
    S_STUCK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_sync;
  logic [7:0]  r_wcnt;
  logic [7:0]  w_wcnt_nxt;
  logic [7:0]  w_wcnt_inc;
  logic        r_expect;
  logic        w_expect_nxt;
  logic        r_trg;
  logic        r_chk_ok;
  logic        r_chk_err;
  logic [15:0] r_id;
  logic [15:0] w_id_plus;
  logic [7:0]  r_err_cnt;
  logic [7:0]  r_glitch_cnt;
  logic        w_trg_s;
  logic        w_trg;
  logic        w_chk_ok;
  logic        w_chk_err;
  logic        w_err_inc;
  logic        w_glitch_inc;
  logic        w_id_inc;
  logic        w_id_resync;

  // The line idles high, so the synchroniser resets to 1 to avoid a false pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], trg_in_N};
    end
  end

  assign w_trg_s    = ~r_sync[1];
  assign w_wcnt_inc = (r_wcnt == 8'hFF) ? r_wcnt : r_wcnt + 8'd1;
  assign w_id_plus  = r_id + 16'd1;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_expect_nxt = r_expect;
    w_trg        = 1'b0;
    w_chk_ok     = 1'b0;
    w_chk_err    = 1'b0;
    w_err_inc    = 1'b0;
    w_glitch_inc = 1'b0;
    w_id_inc     = 1'b0;
    w_id_resync  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (trg_enb_in && w_trg_s) begin
          w_wcnt_nxt  = 8'd1;
          w_state_nxt = S_TRG_HI;
        end
      end
      S_TRG_HI: begin
        if (w_trg_s) begin
          if (r_wcnt >= STUCK_LAST) begin
            w_chk_err   = 1'b1;
            w_err_inc   = 1'b1;
            w_state_nxt = S_STUCK;
          end else begin
            w_wcnt_nxt = w_wcnt_inc;
          end
        end else if (r_wcnt < TRG_MIN) begin
          w_glitch_inc = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (r_wcnt > TRG_MAX) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_trg        = 1'b1;
          w_id_inc     = 1'b1;
          w_expect_nxt = (w_id_plus[11:0] == 12'h001);
          w_wcnt_nxt   = 8'd0;
          w_state_nxt  = S_CHK_WAIT;
        end
      end
      S_CHK_WAIT: begin
        if (w_trg_s) begin
          w_wcnt_nxt  = 8'd1;
          w_state_nxt = S_CHK_HI;
        end else if (r_wcnt >= CHK_LAST) begin
          w_chk_err   = r_expect;
          w_err_inc   = r_expect;
          w_state_nxt = S_IDLE;
        end else begin
          w_wcnt_nxt = w_wcnt_inc;
        end
      end
      S_CHK_HI: begin
        if (w_trg_s) begin
          if (r_wcnt >= STUCK_LAST) begin
            w_chk_err   = 1'b1;
            w_err_inc   = 1'b1;
            w_state_nxt = S_STUCK;
          end else begin
            w_wcnt_nxt = w_wcnt_inc;
          end
        end else begin
          if (r_wcnt >= CHK_MIN && r_wcnt <= CHK_MAX && r_expect) begin
            w_chk_ok = 1'b1;
          end else begin
            // A well-formed check pulse we did not expect means our ID drifted.
            w_chk_err   = 1'b1;
            w_err_inc   = 1'b1;
            w_id_resync = (r_wcnt >= CHK_MIN && r_wcnt <= CHK_MAX);
          end
          w_state_nxt = S_IDLE;
        end
      end
      S_STUCK: begin
        if (!w_trg_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= S_IDLE;
      r_wcnt       <= 8'd0;
      r_expect     <= 1'b0;
      r_trg        <= 1'b0;
      r_chk_ok     <= 1'b0;
      r_chk_err    <= 1'b0;
      r_id         <= 16'd0;
      r_err_cnt    <= 8'd0;
      r_glitch_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_expect  <= w_expect_nxt;
      r_trg     <= w_trg;
      r_chk_ok  <= w_chk_ok;
      r_chk_err <= w_chk_err;
      if (cnt_clr_in) begin
        r_id         <= 16'd0;
        r_err_cnt    <= 8'd0;
        r_glitch_cnt <= 8'd0;
      end else begin
        if (w_id_inc) begin
          r_id <= w_id_plus;
        end else if (w_id_resync) begin
          r_id <= {r_id[15:12], 12'h001};
        end
        if (w_err_inc && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        if (w_glitch_inc && r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
      end
    end
  end

  assign trg_out        = r_trg;
  assign chk_ok_out     = r_chk_ok;
  assign chk_err_out    = r_chk_err;
  assign trg_id_out     = r_id;
  assign err_cnt_out    = r_err_cnt;
  assign glitch_cnt_out = r_glitch_cnt;
  assign busy_out       = (r_state != S_IDLE);
  assign stuck_out      = (r_state == S_STUCK);

endmodule

// File: tb/tb_trg_in_decode.sv
// Self-checking bench for trg_in_decode: strobes are matched against a scoreboard
// of expected events (kind, cycle, ID); counters are compared against a small model.
module tb_trg_in_decode;

  localparam int TRG_MIN = 16;
  localparam int TRG_MAX = 24;
  localparam int CHK_WIN = 20;
  localparam int CHK_MIN = 40;
  localparam int CHK_MAX = 60;
  localparam int STUCK   = 250;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        trg_in_N;
  logic        trg_enb_in;
  logic        cnt_clr_in;
  logic        trg_out;
  logic [15:0] trg_id_out;
  logic        chk_ok_out;
  logic        chk_err_out;
  logic        busy_out;
  logic        stuck_out;
  logic [7:0]  err_cnt_out;
  logic [7:0]  glitch_cnt_out;

  trg_in_decode #(
    .TRG_MIN_WIDTH(TRG_MIN), .TRG_MAX_WIDTH(TRG_MAX), .CHK_WIN(CHK_WIN),
    .CHK_MIN_WIDTH(CHK_MIN), .CHK_MAX_WIDTH(CHK_MAX), .STUCK_LIMIT(STUCK)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .trg_in_N(trg_in_N), .trg_enb_in(trg_enb_in),
    .cnt_clr_in(cnt_clr_in), .trg_out(trg_out), .trg_id_out(trg_id_out),
    .chk_ok_out(chk_ok_out), .chk_err_out(chk_err_out), .busy_out(busy_out),
    .stuck_out(stuck_out), .err_cnt_out(err_cnt_out), .glitch_cnt_out(glitch_cnt_out)
  );

  always #10 clk_in = ~clk_in;

  typedef enum {EV_TRG, EV_OK, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [15:0] id;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] m_id;
  int          m_err;
  int          m_glitch;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Every strobe must match the oldest expected event in kind, cycle and ID.
  always @(negedge clk_in) begin
    ev_t      e;
    ev_kind_t k;
    int       n;
    if (trg_out || chk_ok_out || chk_err_out) begin
      k = trg_out ? EV_TRG : (chk_ok_out ? EV_OK : EV_ERR);
      n = int'(trg_out) + int'(chk_ok_out) + int'(chk_err_out);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got %s cyc=%0d id=%h", k.name(), cyc, trg_id_out);
      end else begin
        e = exp_q.pop_front();
        if (k !== e.kind || cyc !== e.cyc || trg_id_out !== e.id || n != 1) begin
          errors++;
          $display("FAIL strobe got %s cyc=%0d id=%h n=%0d exp %s cyc=%0d id=%h",
                   k.name(), cyc, trg_id_out, n, e.kind.name(), e.cyc, e.id);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push_ev(input ev_kind_t k, input int c, input logic [15:0] id);
    ev_t e;
    e.kind = k; e.cyc = c; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic low_pulse(input int n, output int rel);
    trg_in_N = 1'b0;
    idle(n);
    trg_in_N = 1'b1;
    rel = cyc;
  endtask

  task automatic do_clear();
    cnt_clr_in = 1'b1;
    idle(1);
    cnt_clr_in = 1'b0;
    m_id = 16'd0; m_err = 0; m_glitch = 0;
  endtask

  // One pulse of width w with no check pulse following; outcome taken from the model.
  task automatic trig_pulse(input int w);
    int rel;
    low_pulse(w, rel);
    if (w < TRG_MIN) begin
      if (m_glitch < 255) m_glitch++;
    end else if (w > TRG_MAX) begin
      if (m_err < 255) m_err++;
    end else begin
      m_id++;
      push_ev(EV_TRG, rel + 3, m_id);
      if (m_id[11:0] == 12'h001) begin
        push_ev(EV_ERR, rel + 3 + CHK_WIN, m_id);
        if (m_err < 255) m_err++;
      end
    end
    idle(CHK_WIN + 5);
  endtask

  task automatic trig_with_check(input int gap, input int w);
    int rel;
    int rel2;
    logic expct;
    low_pulse(20, rel);
    m_id++;
    push_ev(EV_TRG, rel + 3, m_id);
    expct = (m_id[11:0] == 12'h001);
    idle(gap);
    low_pulse(w, rel2);
    if (w >= CHK_MIN && w <= CHK_MAX && expct) begin
      push_ev(EV_OK, rel2 + 3, m_id);
    end else begin
      if (w >= CHK_MIN && w <= CHK_MAX) m_id = {m_id[15:12], 12'h001};
      push_ev(EV_ERR, rel2 + 3, m_id);
      if (m_err < 255) m_err++;
    end
    idle(8);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; trg_in_N = 1'b1; trg_enb_in = 1'b0; cnt_clr_in = 1'b0;
    #5 rst_in = 1'b0;
    idle(3);
    checks++;
    if ({trg_out, chk_ok_out, chk_err_out, busy_out, stuck_out} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000",
                         {trg_out, chk_ok_out, chk_err_out, busy_out, stuck_out});
    end
    checks++;
    if ({trg_id_out, err_cnt_out, glitch_cnt_out} !== 32'h0) begin
      errors++; $display("FAIL reset_counters got %h exp 0", {trg_id_out, err_cnt_out, glitch_cnt_out});
    end
    rst_in = 1'b1;
    idle(3);
    m_id = 16'd0; m_err = 0; m_glitch = 0;
    checks++;
    if (busy_out !== 1'b0 || trg_id_out !== 16'h0) begin
      errors++; $display("FAIL post_reset got busy=%b id=%h exp busy=0 id=0", busy_out, trg_id_out);
    end
  endtask

  task automatic test_check_ok();
    trg_enb_in = 1'b1;
    trig_with_check(10, 50);
    checks++;
    if (trg_id_out !== 16'h0001 || err_cnt_out !== 8'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL check_ok got id=%h err=%0d pend=%0d exp id=0001 err=0 pend=0",
                         trg_id_out, err_cnt_out, exp_q.size());
    end
  endtask

  task automatic test_single_trigger();
    int rel;
    int drop;
    for (int i = 0; i < 4; i++) trig_pulse(20);
    checks++;
    if (trg_id_out !== 16'h0005) begin
      errors++; $display("FAIL id_setup got %h exp 0005", trg_id_out);
    end
    low_pulse(20, rel);
    m_id++;
    push_ev(EV_TRG, rel + 3, m_id);
    drop = -1;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (!busy_out && drop < 0) drop = cyc;
    end
    checks++;
    if (drop !== rel + 3 + CHK_WIN) begin
      errors++; $display("FAIL busy_drop got %0d exp %0d", drop - rel, 3 + CHK_WIN);
    end
    checks++;
    if (trg_id_out !== 16'h0006 || exp_q.size() != 0) begin
      errors++; $display("FAIL single_trigger got id=%h pend=%0d exp id=0006 pend=0",
                         trg_id_out, exp_q.size());
    end
  endtask

  task automatic test_missing_check();
    do_clear();
    checks++;
    if ({trg_id_out, err_cnt_out, glitch_cnt_out} !== 32'h0) begin
      errors++; $display("FAIL clear got %h exp 0", {trg_id_out, err_cnt_out, glitch_cnt_out});
    end
    trig_pulse(20);
    checks++;
    if (err_cnt_out !== 8'd1 || trg_id_out !== 16'h0001 || exp_q.size() != 0) begin
      errors++; $display("FAIL missing_check got err=%0d id=%h pend=%0d exp err=1 id=0001 pend=0",
                         err_cnt_out, trg_id_out, exp_q.size());
    end
  endtask

  task automatic test_resync();
    do_clear();
    trig_with_check(10, 50);
    for (int i = 0; i < 16'h0122; i++) trig_pulse(20);
    checks++;
    if (trg_id_out !== 16'h0123 || err_cnt_out !== 8'd0) begin
      errors++; $display("FAIL resync_setup got id=%h err=%0d exp id=0123 err=0", trg_id_out, err_cnt_out);
    end
    trig_with_check(10, 50);
    checks++;
    if (trg_id_out !== 16'h0001 || err_cnt_out !== 8'd1 || exp_q.size() != 0) begin
      errors++; $display("FAIL resync got id=%h err=%0d pend=%0d exp id=0001 err=1 pend=0",
                         trg_id_out, err_cnt_out, exp_q.size());
    end
  endtask

  task automatic test_glitch_stuck();
    int low_at;
    do_clear();
    trig_pulse(5);
    trig_pulse(30);
    low_at = cyc;
    push_ev(EV_ERR, low_at + 2 + STUCK, m_id);
    m_err++;
    trg_in_N = 1'b0;
    idle(300);
    checks++;
    if (stuck_out !== 1'b1) begin
      errors++; $display("FAIL stuck_high got %b exp 1", stuck_out);
    end
    trg_in_N = 1'b1;
    idle(2);
    checks++;
    if (stuck_out !== 1'b1) begin
      errors++; $display("FAIL stuck_hold got %b exp 1", stuck_out);
    end
    idle(1);
    checks++;
    if (stuck_out !== 1'b0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL stuck_release got stuck=%b busy=%b exp 0 0", stuck_out, busy_out);
    end
    idle(5);
    checks++;
    if (glitch_cnt_out !== 8'd1 || err_cnt_out !== 8'd2 || trg_id_out !== 16'h0 || exp_q.size() != 0) begin
      errors++; $display("FAIL glitch_stuck got g=%0d e=%0d id=%h pend=%0d exp g=1 e=2 id=0 pend=0",
                         glitch_cnt_out, err_cnt_out, trg_id_out, exp_q.size());
    end
  endtask

  task automatic test_disable();
    trg_enb_in = 1'b0;
    trg_in_N = 1'b0;
    idle(10);
    checks++;
    if (busy_out !== 1'b0) begin
      errors++; $display("FAIL disabled_busy got %b exp 0", busy_out);
    end
    idle(10);
    trg_in_N = 1'b1;
    idle(CHK_WIN + 5);
    checks++;
    if (trg_id_out !== m_id || glitch_cnt_out !== 8'(m_glitch) || err_cnt_out !== 8'(m_err)) begin
      errors++; $display("FAIL disabled got id=%h g=%0d e=%0d exp id=%h g=%0d e=%0d",
                         trg_id_out, glitch_cnt_out, err_cnt_out, m_id, m_glitch, m_err);
    end
    trg_enb_in = 1'b1;
  endtask

  task automatic test_reset_mid_chk();
    int rel;
    low_pulse(20, rel);
    m_id++;
    push_ev(EV_TRG, rel + 3, m_id);
    idle(10);
    trg_in_N = 1'b0;
    idle(20);
    rst_in = 1'b0;
    #1;
    checks++;
    if ({trg_out, chk_ok_out, chk_err_out, busy_out, stuck_out, trg_id_out, err_cnt_out, glitch_cnt_out} !== 37'h0) begin
      errors++; $display("FAIL reset_mid_chk got busy=%b id=%h e=%0d g=%0d exp all 0",
                         busy_out, trg_id_out, err_cnt_out, glitch_cnt_out);
    end
    trg_in_N = 1'b1;
    idle(3);
    rst_in = 1'b1;
    m_id = 16'd0; m_err = 0; m_glitch = 0;
    idle(2);
    trig_pulse(20);
    checks++;
    if (trg_id_out !== 16'h0001 || exp_q.size() != 0) begin
      errors++; $display("FAIL after_reset_trigger got id=%h pend=%0d exp id=0001 pend=0",
                         trg_id_out, exp_q.size());
    end
  endtask

  task automatic test_clear_priority();
    int rel;
    low_pulse(20, rel);
    push_ev(EV_TRG, rel + 3, 16'h0000);
    idle(2);
    cnt_clr_in = 1'b1;
    idle(1);
    cnt_clr_in = 1'b0;
    m_id = 16'd0; m_err = 0; m_glitch = 0;
    idle(CHK_WIN + 5);
    checks++;
    if (trg_id_out !== 16'h0 || err_cnt_out !== 8'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL clear_priority got id=%h e=%0d pend=%0d exp id=0 e=0 pend=0",
                         trg_id_out, err_cnt_out, exp_q.size());
    end
  endtask

  task automatic test_width_bounds();
    int ws[4] = '{TRG_MIN - 1, TRG_MIN, TRG_MAX, TRG_MAX + 1};
    foreach (ws[i]) trig_pulse(ws[i]);
    checks++;
    if (trg_id_out !== m_id || err_cnt_out !== 8'(m_err) || glitch_cnt_out !== 8'(m_glitch) || exp_q.size() != 0) begin
      errors++; $display("FAIL width_bounds got id=%h e=%0d g=%0d exp id=%h e=%0d g=%0d",
                         trg_id_out, err_cnt_out, glitch_cnt_out, m_id, m_err, m_glitch);
    end
  endtask

  task automatic test_glitch_saturate();
    for (int i = 0; i < 260; i++) trig_pulse(1);
    checks++;
    if (glitch_cnt_out !== 8'd255 || m_glitch != 255 || err_cnt_out !== 8'(m_err)) begin
      errors++; $display("FAIL glitch_saturate got g=%0d e=%0d exp g=255 e=%0d",
                         glitch_cnt_out, err_cnt_out, m_err);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout cyc=%0d exp finish before 2ms", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_check_ok();
    test_single_trigger();
    test_missing_check();
    test_resync();
    test_glitch_stuck();
    test_disable();
    test_reset_mid_chk();
    test_clear_priority();
    test_width_bounds();
    test_glitch_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
